nasti_write_arbiter: RTL and testbench
======================================

// Module: nasti_write_arbiter
// PURPOSE
//  Shares one NASTI write port (AW/W/B) among NUM_MASTERS requesters, typically in front of
//  nasti_narrower_writer. Round-robin grant on AW; grant held until the B handshake completes.
//  One transaction outstanding at a time; the slave side sees a single, strictly ordered master.
// PARAMETERS
//  NUM_MASTERS  2   number of requesting masters (>=2)
//  ID_WIDTH     2   NASTI ID width, passed through unchanged
//  ADDR_WIDTH   32  NASTI address width
//  DATA_WIDTH   64  W data width (both sides)
//  USER_WIDTH   1   USER field width
// PORTS (m_* are packed NUM_MASTERS-wide; master i occupies slice i)
//  clk               in   1            clock
//  rst               in   1            reset, asynchronous, active-high
//  m_aw_id/addr      in   N*ID/N*ADDR  AW id, address
//  m_aw_len/size     in   N*8/N*3      AW burst length, beat size
//  m_aw_burst/lock   in   N*2/N*1      AW burst type, lock
//  m_aw_cache/prot/qos/region/user  in  N*4/N*3/N*4/N*4/N*USER  AW attributes
//  m_aw_valid        in   N            AW valid
//  m_aw_ready        out  N            AW ready
//  m_w_data/strb     in   N*DATA/N*DATA/8  W data, strobes
//  m_w_last/user     in   N/N*USER     W last, user
//  m_w_valid         in   N            W valid
//  m_w_ready         out  N            W ready
//  m_b_id/resp/user  out  N*ID/N*2/N*USER  B response (all masters see slave value)
//  m_b_valid         out  N            B valid
//  m_b_ready         in   N            B ready
//  s_aw_*, s_w_*, s_b_*  single-width mirror of the above, opposite directions
// BEHAVIOUR
//  Reset: state=S_IDLE, grant=0, rr_ptr=NUM_MASTERS-1 (master 0 wins first), beat_cnt=0.
//   All *_valid/*_ready outputs 0 while in S_IDLE and during reset.
//  S_IDLE: if any m_aw_valid, pick first set bit searching from rr_ptr+1 (mod N); register
//   grant, latch len of winner, go S_AW. One cycle of arbitration latency; m_aw_ready=0 here.
//  S_AW: s_aw_* = m_aw_*[grant]; s_aw_valid=m_aw_valid[grant]; m_aw_ready[grant]=s_aw_ready.
//   Handshake -> S_W, beat_cnt=0. Other masters' ready stays 0.
//  S_W: s_w_* = m_w_*[grant]; s_w_valid=m_w_valid[grant]; m_w_ready[grant]=s_w_ready.
//   s_w_last generated as (beat_cnt==len); beat_cnt++ per handshake. Handshake with last -> S_B.
//   Master m_w_last ignored for sequencing; mismatch vs generated last -> $error (sim only).
//   W beats offered before the AW handshake are not accepted (no W-before-AW).
//  S_B: m_b_valid[grant]=s_b_valid; s_b_ready=m_b_ready[grant]; b id/resp/user pass through.
//   Handshake -> S_IDLE, rr_ptr=grant. New arbitration starts the following cycle.
//  Simultaneous requests: strict round-robin; a master never wins twice while another waits.
//  Requester dropping m_aw_valid in S_AW is illegal (AXI); no recovery, assertion flags it.
//  len=0: single beat, s_w_last on first beat. len=255: beat_cnt 8-bit, no wrap before last.
//  Reset mid-burst: immediate return to S_IDLE; in-flight transaction abandoned, no B emitted.
// STRUCTURE
//  nasti_arb_pkg: state enum {S_IDLE,S_AW,S_W,S_B}; clog2-based GRANT_WIDTH helper.
//  Reuse NastiReq from nasti_request.vh for the latched AW fields.
//  Sub-module nasti_rr_picker: combinational req[N]+ptr -> one-hot/index grant, any_req.
// TESTING
//  1 Master 0 alone: AW len=3 addr=0x100 -> s_aw after 1-cycle gap, 4 W beats, last on 4th, B routed to m0.
//  2 M0,M1 request same cycle from reset -> m0 served fully, then m1; next tie -> m0 again.
//  3 len=0 from m1 with s_w_ready stalled 5 cycles -> single beat, s_w_last=1, m1 w_ready tracks stall.
//  4 m1 holds m_w_valid before AW granted -> no W handshake until state S_W.
//  5 s_b_valid with m_b_ready=0 for 3 cycles -> state held S_B, no new grant, m0 aw_ready=0.
//  6 rst pulsed mid-S_W (beat 2 of 4) -> all valids/readys 0 same cycle, next grant to m0.

Source files
------------

// File: rtl/nasti_arb_pkg.sv
// Shared types and helpers for the NASTI write-port arbiter.
package nasti_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } arb_state_e;

    // Index width for a grant over n requesters; never narrower than one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nasti_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module nasti_rr_picker
    import nasti_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = grant_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [GW-1:0] grant_idx,
    output logic          any_req
);

    logic [GW-1:0] idx;

    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(ptr) + k) % N);
            if (!any_req && req[idx]) begin
                any_req       = 1'b1;
                grant_idx     = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nasti_write_arbiter.sv
// Round-robin arbiter sharing one NASTI write port (AW/W/B) among NUM_MASTERS requesters,
// one transaction outstanding; grant held from AW arbitration until the B handshake.
module nasti_write_arbiter
    import nasti_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ID_WIDTH    = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int USER_WIDTH  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]    m_aw_id,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_aw_addr,
    input  logic [NUM_MASTERS*8-1:0]           m_aw_len,
    input  logic [NUM_MASTERS*3-1:0]           m_aw_size,
    input  logic [NUM_MASTERS*2-1:0]           m_aw_burst,
    input  logic [NUM_MASTERS-1:0]             m_aw_lock,
    input  logic [NUM_MASTERS*4-1:0]           m_aw_cache,
    input  logic [NUM_MASTERS*3-1:0]           m_aw_prot,
    input  logic [NUM_MASTERS*4-1:0]           m_aw_qos,
    input  logic [NUM_MASTERS*4-1:0]           m_aw_region,
    input  logic [NUM_MASTERS*USER_WIDTH-1:0]  m_aw_user,
    input  logic [NUM_MASTERS-1:0]             m_aw_valid,
    output logic [NUM_MASTERS-1:0]             m_aw_ready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_w_data,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_w_strb,
    input  logic [NUM_MASTERS-1:0]             m_w_last,
    input  logic [NUM_MASTERS*USER_WIDTH-1:0]  m_w_user,
    input  logic [NUM_MASTERS-1:0]             m_w_valid,
    output logic [NUM_MASTERS-1:0]             m_w_ready,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]    m_b_id,
    output logic [NUM_MASTERS*2-1:0]           m_b_resp,
    output logic [NUM_MASTERS*USER_WIDTH-1:0]  m_b_user,
    output logic [NUM_MASTERS-1:0]             m_b_valid,
    input  logic [NUM_MASTERS-1:0]             m_b_ready,
    output logic [ID_WIDTH-1:0]                s_aw_id,
    output logic [ADDR_WIDTH-1:0]              s_aw_addr,
    output logic [7:0]                         s_aw_len,
    output logic [2:0]                         s_aw_size,
    output logic [1:0]                         s_aw_burst,
    output logic                               s_aw_lock,
    output logic [3:0]                         s_aw_cache,
    output logic [2:0]                         s_aw_prot,
    output logic [3:0]                         s_aw_qos,
    output logic [3:0]                         s_aw_region,
    output logic [USER_WIDTH-1:0]              s_aw_user,
    output logic                               s_aw_valid,
    input  logic                               s_aw_ready,
    output logic [DATA_WIDTH-1:0]              s_w_data,
    output logic [DATA_WIDTH/8-1:0]            s_w_strb,
    output logic                               s_w_last,
    output logic [USER_WIDTH-1:0]              s_w_user,
    output logic                               s_w_valid,
    input  logic                               s_w_ready,
    input  logic [ID_WIDTH-1:0]                s_b_id,
    input  logic [1:0]                         s_b_resp,
    input  logic [USER_WIDTH-1:0]              s_b_user,
    input  logic                               s_b_valid,
    output logic                               s_b_ready
);

    localparam int N  = NUM_MASTERS;
    localparam int GW = grant_width(N);
    localparam int SW = DATA_WIDTH / 8;

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [N-1:0]  grant_oh_q, grant_oh_d;
    logic [7:0]    len_q, len_d, beat_cnt_q, beat_cnt_d;

    logic [N-1:0]  pick_oh;
    logic [GW-1:0] pick_idx;
    logic          any_req;

    nasti_rr_picker #(.N(N), .GW(GW)) u_picker (
        .req       (m_aw_valid),
        .ptr       (rr_ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    // Payload fields follow the held grant at all times; only valid/ready are state-gated.
    assign s_aw_id     = m_aw_id[grant_q*ID_WIDTH +: ID_WIDTH];
    assign s_aw_addr   = m_aw_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_aw_len    = m_aw_len[grant_q*8 +: 8];
    assign s_aw_size   = m_aw_size[grant_q*3 +: 3];
    assign s_aw_burst  = m_aw_burst[grant_q*2 +: 2];
    assign s_aw_lock   = m_aw_lock[grant_q];
    assign s_aw_cache  = m_aw_cache[grant_q*4 +: 4];
    assign s_aw_prot   = m_aw_prot[grant_q*3 +: 3];
    assign s_aw_qos    = m_aw_qos[grant_q*4 +: 4];
    assign s_aw_region = m_aw_region[grant_q*4 +: 4];
    assign s_aw_user   = m_aw_user[grant_q*USER_WIDTH +: USER_WIDTH];
    assign s_w_data    = m_w_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign s_w_strb    = m_w_strb[grant_q*SW +: SW];
    assign s_w_user    = m_w_user[grant_q*USER_WIDTH +: USER_WIDTH];
    assign m_b_id      = {N{s_b_id}};
    assign m_b_resp    = {N{s_b_resp}};
    assign m_b_user    = {N{s_b_user}};

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        s_aw_valid = 1'b0;
        m_aw_ready = '0;
        s_w_valid  = 1'b0;
        s_w_last   = 1'b0;
        m_w_ready  = '0;
        m_b_valid  = '0;
        s_b_ready  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                    len_d      = m_aw_len[pick_idx*8 +: 8];
                    state_d    = S_AW;
                end
            end
            S_AW: begin
                s_aw_valid = m_aw_valid[grant_q];
                m_aw_ready = grant_oh_q & {N{s_aw_ready}};
                if (s_aw_valid && s_aw_ready) begin
                    beat_cnt_d = '0;
                    state_d    = S_W;
                end
            end
            S_W: begin
                // Last is derived from the latched length, not trusted from the master.
                s_w_valid = m_w_valid[grant_q];
                s_w_last  = (beat_cnt_q == len_q);
                m_w_ready = grant_oh_q & {N{s_w_ready}};
                if (s_w_valid && s_w_ready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (s_w_last) state_d = S_B;
                end
            end
            S_B: begin
                m_b_valid = grant_oh_q & {N{s_b_valid}};
                s_b_ready = m_b_ready[grant_q];
                if (s_b_valid && s_b_ready) begin
                    rr_ptr_d = grant_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_oh_q <= {{(N-1){1'b0}}, 1'b1};
            rr_ptr_q   <= GW'(N - 1);
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    aw_held_until_accepted: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_AW) |-> m_aw_valid[grant_q])
        else $error("granted master dropped aw_valid before the AW handshake");

    w_last_consistent: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_W && s_w_valid && s_w_ready) |-> (m_w_last[grant_q] == s_w_last))
        else $error("master w_last disagrees with the burst length");

endmodule

// File: tb/tb_nasti_write_arbiter.sv
// Directed bench for nasti_write_arbiter: single master, ties, stalls, early W and mid-burst reset.
module tb_nasti_write_arbiter;

    localparam int N   = 2;
    localparam int IDW = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int UW  = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N*IDW-1:0]     m_aw_id;
    logic [N*AW-1:0]      m_aw_addr;
    logic [N*8-1:0]       m_aw_len;
    logic [N*3-1:0]       m_aw_size;
    logic [N*2-1:0]       m_aw_burst;
    logic [N-1:0]         m_aw_lock;
    logic [N*4-1:0]       m_aw_cache;
    logic [N*3-1:0]       m_aw_prot;
    logic [N*4-1:0]       m_aw_qos;
    logic [N*4-1:0]       m_aw_region;
    logic [N*UW-1:0]      m_aw_user;
    logic [N-1:0]         m_aw_valid;
    logic [N-1:0]         m_aw_ready;
    logic [N*DW-1:0]      m_w_data;
    logic [N*DW/8-1:0]    m_w_strb;
    logic [N-1:0]         m_w_last;
    logic [N*UW-1:0]      m_w_user;
    logic [N-1:0]         m_w_valid;
    logic [N-1:0]         m_w_ready;
    logic [N*IDW-1:0]     m_b_id;
    logic [N*2-1:0]       m_b_resp;
    logic [N*UW-1:0]      m_b_user;
    logic [N-1:0]         m_b_valid;
    logic [N-1:0]         m_b_ready;
    logic [IDW-1:0]       s_aw_id;
    logic [AW-1:0]        s_aw_addr;
    logic [7:0]           s_aw_len;
    logic [2:0]           s_aw_size;
    logic [1:0]           s_aw_burst;
    logic                 s_aw_lock;
    logic [3:0]           s_aw_cache;
    logic [2:0]           s_aw_prot;
    logic [3:0]           s_aw_qos;
    logic [3:0]           s_aw_region;
    logic [UW-1:0]        s_aw_user;
    logic                 s_aw_valid;
    logic                 s_aw_ready;
    logic [DW-1:0]        s_w_data;
    logic [DW/8-1:0]      s_w_strb;
    logic                 s_w_last;
    logic [UW-1:0]        s_w_user;
    logic                 s_w_valid;
    logic                 s_w_ready;
    logic [IDW-1:0]       s_b_id;
    logic [1:0]           s_b_resp;
    logic [UW-1:0]        s_b_user;
    logic                 s_b_valid;
    logic                 s_b_ready;

    int checks = 0;
    int errors = 0;

    nasti_write_arbiter #(
        .NUM_MASTERS (N),
        .ID_WIDTH    (IDW),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .USER_WIDTH  (UW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_aw_id     (m_aw_id),
        .m_aw_addr   (m_aw_addr),
        .m_aw_len    (m_aw_len),
        .m_aw_size   (m_aw_size),
        .m_aw_burst  (m_aw_burst),
        .m_aw_lock   (m_aw_lock),
        .m_aw_cache  (m_aw_cache),
        .m_aw_prot   (m_aw_prot),
        .m_aw_qos    (m_aw_qos),
        .m_aw_region (m_aw_region),
        .m_aw_user   (m_aw_user),
        .m_aw_valid  (m_aw_valid),
        .m_aw_ready  (m_aw_ready),
        .m_w_data    (m_w_data),
        .m_w_strb    (m_w_strb),
        .m_w_last    (m_w_last),
        .m_w_user    (m_w_user),
        .m_w_valid   (m_w_valid),
        .m_w_ready   (m_w_ready),
        .m_b_id      (m_b_id),
        .m_b_resp    (m_b_resp),
        .m_b_user    (m_b_user),
        .m_b_valid   (m_b_valid),
        .m_b_ready   (m_b_ready),
        .s_aw_id     (s_aw_id),
        .s_aw_addr   (s_aw_addr),
        .s_aw_len    (s_aw_len),
        .s_aw_size   (s_aw_size),
        .s_aw_burst  (s_aw_burst),
        .s_aw_lock   (s_aw_lock),
        .s_aw_cache  (s_aw_cache),
        .s_aw_prot   (s_aw_prot),
        .s_aw_qos    (s_aw_qos),
        .s_aw_region (s_aw_region),
        .s_aw_user   (s_aw_user),
        .s_aw_valid  (s_aw_valid),
        .s_aw_ready  (s_aw_ready),
        .s_w_data    (s_w_data),
        .s_w_strb    (s_w_strb),
        .s_w_last    (s_w_last),
        .s_w_user    (s_w_user),
        .s_w_valid   (s_w_valid),
        .s_w_ready   (s_w_ready),
        .s_b_id      (s_b_id),
        .s_b_resp    (s_b_resp),
        .s_b_user    (s_b_user),
        .s_b_valid   (s_b_valid),
        .s_b_ready   (s_b_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1-2 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aw(input int m, input logic [7:0] len, input logic [31:0] addr);
        m_aw_valid[m]          = 1'b1;
        m_aw_len[m*8 +: 8]     = len;
        m_aw_addr[m*AW +: AW]  = addr;
        m_aw_id[m*IDW +: IDW]  = IDW'(m + 1);
    endtask

    // Runs one full transaction for master m, starting in S_IDLE with its AW request already up.
    task automatic serve(input int m, input logic [7:0] len, input logic [31:0] addr);
        logic [63:0] beat;
        #1;
        check("idle_gap_no_aw", {63'd0, s_aw_valid}, 64'd0);
        tick();
        check("aw_grant", {62'd0, m_aw_ready}, 64'd1 << m);
        check("aw_addr", {32'd0, s_aw_addr}, {32'd0, addr});
        check("aw_len", {56'd0, s_aw_len}, {56'd0, len});
        check("aw_id", {62'd0, s_aw_id}, 64'(m + 1));
        check("no_w_before_aw", {62'd0, m_w_ready}, 64'd0);
        tick();
        m_aw_valid[m] = 1'b0;
        m_w_valid[m]  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            beat                  = {addr, 32'(b)};
            m_w_data[m*DW +: DW]  = beat;
            m_w_last[m]           = (b == int'(len));
            #1;
            check("w_ready_route", {62'd0, m_w_ready}, 64'd1 << m);
            check("w_data", s_w_data, beat);
            check("w_last", {63'd0, s_w_last}, {63'd0, (b == int'(len))});
            tick();
        end
        m_w_valid[m] = 1'b0;
        m_w_last[m]  = 1'b0;
        s_b_valid    = 1'b1;
        s_b_resp     = 2'(m + 1);
        m_b_ready[m] = 1'b1;
        #1;
        check("b_route", {62'd0, m_b_valid}, 64'd1 << m);
        check("b_ready", {63'd0, s_b_ready}, 64'd1);
        check("b_resp_bcast", {60'd0, m_b_resp}, {60'd0, {2{2'(m + 1)}}});
        tick();
        s_b_valid    = 1'b0;
        m_b_ready[m] = 1'b0;
    endtask

    task automatic check_all_idle(input string tag);
        check(tag, {57'd0, s_aw_valid, m_aw_ready, s_w_valid, m_w_ready, m_b_valid[0]},
              64'd0);
        check({tag, "_b"}, {62'd0, m_b_valid[1], s_b_ready}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        m_aw_id    = '0;  m_aw_addr  = '0;  m_aw_len    = '0;  m_aw_size = '0;
        m_aw_burst = '0;  m_aw_lock  = '0;  m_aw_cache  = '0;  m_aw_prot = '0;
        m_aw_qos   = '0;  m_aw_region = '0; m_aw_user   = '0;  m_aw_valid = '0;
        m_w_data   = '0;  m_w_strb   = '1;  m_w_last    = '0;  m_w_user  = '0;
        m_w_valid  = '0;  m_b_ready  = '0;
        s_aw_ready = 1'b1; s_w_ready = 1'b1;
        s_b_id     = 2'd1; s_b_resp  = '0;  s_b_user    = '0;  s_b_valid = 1'b0;

        // Reset holds every handshake output low even with requests pending.
        repeat (2) tick();
        set_aw(0, 8'd3, 32'h100);
        m_w_valid = 2'b11;
        s_b_valid = 1'b1;
        #1;
        check_all_idle("reset_outputs");
        m_w_valid = '0;
        s_b_valid = 1'b0;
        rst = 1'b0;

        // Master 0 alone, 4-beat burst.
        serve(0, 8'd3, 32'h100);

        // Tie from reset: m0, then m1, then the next tie goes to m0 again.
        rst = 1'b1;
        set_aw(0, 8'd1, 32'h200);
        set_aw(1, 8'd2, 32'h300);
        tick();
        rst = 1'b0;
        serve(0, 8'd1, 32'h200);
        serve(1, 8'd2, 32'h300);
        set_aw(0, 8'd0, 32'h210);
        set_aw(1, 8'd0, 32'h310);
        serve(0, 8'd0, 32'h210);
        serve(1, 8'd0, 32'h310);

        // Single-beat burst from m1 with the slave stalling W for 5 cycles.
        set_aw(1, 8'd0, 32'h400);
        #1;
        check("t3_idle_gap", {63'd0, s_aw_valid}, 64'd0);
        tick();
        check("t3_aw_grant", {62'd0, m_aw_ready}, 64'h2);
        tick();
        m_aw_valid[1]        = 1'b0;
        s_w_ready            = 1'b0;
        m_w_valid[1]         = 1'b1;
        m_w_last[1]          = 1'b1;
        m_w_data[DW +: DW]   = 64'h400;
        repeat (5) begin
            #1;
            check("t3_w_valid", {63'd0, s_w_valid}, 64'd1);
            check("t3_w_last", {63'd0, s_w_last}, 64'd1);
            check("t3_w_stall", {62'd0, m_w_ready}, 64'd0);
            tick();
        end
        s_w_ready = 1'b1;
        #1;
        check("t3_w_release", {62'd0, m_w_ready}, 64'h2);
        tick();
        m_w_valid[1] = 1'b0;
        m_w_last[1]  = 1'b0;

        // B back-pressure from m1 while m0 is already requesting.
        set_aw(0, 8'd2, 32'h500);
        s_b_valid = 1'b1;
        s_b_resp  = 2'd3;
        repeat (3) begin
            #1;
            check("t5_b_valid_held", {62'd0, m_b_valid}, 64'h2);
            check("t5_b_ready_low", {63'd0, s_b_ready}, 64'd0);
            check("t5_no_new_grant", {61'd0, m_aw_ready, s_aw_valid}, 64'd0);
            tick();
        end
        m_b_ready[1] = 1'b1;
        #1;
        check("t5_b_ready", {63'd0, s_b_ready}, 64'd1);
        tick();
        s_b_valid    = 1'b0;
        m_b_ready[1] = 1'b0;

        // m1 offers W early; it must not be accepted while m0 owns the port or before its own AW.
        m_w_valid[1] = 1'b1;
        set_aw(1, 8'd1, 32'h600);
        serve(0, 8'd2, 32'h500);
        serve(1, 8'd1, 32'h600);
        set_aw(0, 8'd0, 32'h680);
        serve(0, 8'd0, 32'h680);

        // Reset during beat 2 of a 4-beat burst from m1; the round-robin pointer must restart.
        set_aw(1, 8'd3, 32'h700);
        tick();
        tick();
        m_aw_valid[1] = 1'b0;
        m_w_valid[1]  = 1'b1;
        for (int b = 0; b < 2; b++) begin
            m_w_data[DW +: DW] = 64'(b);
            tick();
        end
        #1;
        check("t6_mid_burst", {63'd0, s_w_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check_all_idle("t6_reset_outputs");
        m_w_valid[1] = 1'b0;
        set_aw(0, 8'd0, 32'h780);
        set_aw(1, 8'd0, 32'h790);
        tick();
        rst = 1'b0;
        serve(0, 8'd0, 32'h780);
        serve(1, 8'd0, 32'h790);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
